seq_display_ctrl: RTL and testbench

- Sequencing controller for the 4-bit two's-complement 7-segment display path.
- Steps a signed value through a programmable range [lo, hi] at a fixed tick rate, in wrap-around or bounce mode, with start/stop/pause/load control.
- Drives the `number` input of the downstream display decoder, plus a blank request.
- Sits between the board control inputs and the decoder; all outputs are registered.

---
 rtl/seq_disp_pkg.sv | 29 ++
 rtl/seq_display_ctrl_tick_prescaler.sv | 32 +++
 rtl/seq_display_ctrl.sv | 165 ++++++++++++++++
 tb/tb_seq_display_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_disp_pkg.sv
// Shared types, constants and a signed clamp helper for the display sequencer.
// Values are 4-bit two's-complement display numbers.
package seq_disp_pkg;

    localparam int   NUM_W       = 4;
    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } seq_state_t;

    typedef logic signed [NUM_W-1:0] num_t;

    function automatic num_t clamp_s(input num_t v, input num_t lo, input num_t hi);
        if (v < lo) begin
            return lo;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/seq_display_ctrl_tick_prescaler.sv
// Step-rate divider: tick is high in the cycle the count sits at TICK_DIV-1 while enabled.
// clr restarts the period; en low freezes the count without losing the phase.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = en && w_at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_display_ctrl.sv
// Steps a signed display value through [lo, hi] at one step per TICK_DIV cycles, wrap or bounce.
// All outputs registered; start/load/stop take effect on the edge they are sampled.
module seq_display_ctrl
    import seq_disp_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic             dir_init,
    input  logic [NUM_W-1:0] lo_lim,
    input  logic [NUM_W-1:0] hi_lim,
    input  logic             load,
    input  logic [NUM_W-1:0] load_val,
    output logic [NUM_W-1:0] number,
    output logic             blank,
    output logic             busy,
    output logic             step,
    output logic             wrap
);

    seq_state_t r_state, w_state_nxt;
    num_t       r_number, w_number_nxt;
    num_t       r_lo, w_lo_nxt;
    num_t       r_hi, w_hi_nxt;
    logic       r_dir, w_dir_nxt;
    logic       r_blank, w_blank_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_step, w_step_nxt;
    logic       r_wrap, w_wrap_nxt;

    num_t       w_lo_in, w_hi_in, w_load_in;
    logic       w_lims_ok, w_active, w_accept;
    logic       w_pre_clr, w_pre_en, w_tick;

    assign w_lo_in   = lo_lim;
    assign w_hi_in   = hi_lim;
    assign w_load_in = load_val;
    assign w_lims_ok = (w_lo_in <= w_hi_in);
    assign w_active  = (r_state == RUN) || (r_state == PAUSED);
    assign w_accept  = (r_state == IDLE) && start && w_lims_ok;

    // Prescaler advances only on cycles where nothing of higher priority than the tick is asserted.
    assign w_pre_en  = w_active && !stop && !load && !pause;
    assign w_pre_clr = stop || (!stop && w_accept) || (!stop && w_active && load);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_pre_clr),
        .en    (w_pre_en),
        .tick  (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_number_nxt = r_number;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_dir_nxt    = r_dir;
        w_blank_nxt  = r_blank;
        w_busy_nxt   = r_busy;
        w_step_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;

        if (stop) begin
            w_state_nxt = IDLE;
            w_blank_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_nxt  = RUN;
                        w_busy_nxt   = 1'b1;
                        w_blank_nxt  = 1'b0;
                        w_lo_nxt     = w_lo_in;
                        w_hi_nxt     = w_hi_in;
                        w_dir_nxt    = dir_init;
                        w_number_nxt = (dir_init == DIR_DOWN) ? w_hi_in : w_lo_in;
                    end
                end
                RUN, PAUSED: begin
                    if (load) begin
                        w_number_nxt = clamp_s(w_load_in, r_lo, r_hi);
                    end else if (pause) begin
                        w_state_nxt = PAUSED;
                    end else begin
                        w_state_nxt = RUN;
                        if (w_tick) begin
                            w_step_nxt = 1'b1;
                            if (r_dir == DIR_UP) begin
                                if (r_number < r_hi) begin
                                    w_number_nxt = r_number + num_t'(1);
                                end else begin
                                    w_wrap_nxt = 1'b1;
                                    if (mode == MODE_BOUNCE) begin
                                        w_dir_nxt    = DIR_DOWN;
                                        w_number_nxt = (r_lo == r_hi) ? r_hi : r_hi - num_t'(1);
                                    end else begin
                                        w_number_nxt = r_lo;
                                    end
                                end
                            end else begin
                                if (r_number > r_lo) begin
                                    w_number_nxt = r_number - num_t'(1);
                                end else begin
                                    w_wrap_nxt = 1'b1;
                                    if (mode == MODE_BOUNCE) begin
                                        w_dir_nxt    = DIR_UP;
                                        w_number_nxt = (r_lo == r_hi) ? r_lo : r_lo + num_t'(1);
                                    end else begin
                                        w_number_nxt = r_hi;
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_blank_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_number <= '0;
            r_lo     <= num_t'(-8);
            r_hi     <= num_t'(7);
            r_dir    <= DIR_UP;
            r_blank  <= 1'b1;
            r_busy   <= 1'b0;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_number <= w_number_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_dir    <= w_dir_nxt;
            r_blank  <= w_blank_nxt;
            r_busy   <= w_busy_nxt;
            r_step   <= w_step_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign number = r_number;
    assign blank  = r_blank;
    assign busy   = r_busy;
    assign step   = r_step;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_seq_display_ctrl.sv
// Directed scenarios plus random traffic, each cycle checked against a countdown-based reference model.
module tb_seq_display_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, pause, mode, dir_init, load;
    logic [3:0] lo_lim, hi_lim, load_val;
    logic [3:0] number;
    logic       blank, busy, step, wrap;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: number/limits as plain ints, steps counted down per active cycle.
    int m_num, m_lo, m_hi, m_dir, m_left;
    bit m_blank, m_busy, m_step, m_wrap;

    always #5 clk = ~clk;

    seq_display_ctrl #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .dir_init (dir_init),
        .lo_lim   (lo_lim),
        .hi_lim   (hi_lim),
        .load     (load),
        .load_val (load_val),
        .number   (number),
        .blank    (blank),
        .busy     (busy),
        .step     (step),
        .wrap     (wrap)
    );

    function automatic int sv4(input logic [3:0] x);
        logic signed [3:0] t;
        t = x;
        return int'(t);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model_reset();
        m_num = 0; m_lo = -8; m_hi = 7; m_dir = 0; m_left = TD;
        m_blank = 1; m_busy = 0; m_step = 0; m_wrap = 0;
    endtask

    task automatic model_cycle();
        int lv;
        m_step = 0;
        m_wrap = 0;
        if (stop) begin
            m_busy = 0; m_blank = 1; m_left = TD;
        end else if (!m_busy) begin
            if (start && sv4(lo_lim) <= sv4(hi_lim)) begin
                m_lo = sv4(lo_lim); m_hi = sv4(hi_lim); m_dir = int'(dir_init);
                m_num = m_dir ? m_hi : m_lo;
                m_busy = 1; m_blank = 0; m_left = TD;
            end
        end else if (load) begin
            lv = sv4(load_val);
            m_num = (lv < m_lo) ? m_lo : (lv > m_hi) ? m_hi : lv;
            m_left = TD;
        end else if (!pause) begin
            m_left--;
            if (m_left == 0) begin
                m_left = TD;
                m_step = 1;
                if (m_dir == 0) begin
                    if (m_num < m_hi) m_num++;
                    else if (!mode) begin m_num = m_lo; m_wrap = 1; end
                    else begin m_dir = 1; m_num = (m_lo == m_hi) ? m_hi : m_hi - 1; m_wrap = 1; end
                end else begin
                    if (m_num > m_lo) m_num--;
                    else if (!mode) begin m_num = m_hi; m_wrap = 1; end
                    else begin m_dir = 0; m_num = (m_lo == m_hi) ? m_lo : m_lo + 1; m_wrap = 1; end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e;
        e = 4'(m_num);
        check("number", {28'b0, number}, {28'b0, e});
        check("blank",  {31'b0, blank},  {31'b0, m_blank});
        check("busy",   {31'b0, busy},   {31'b0, m_busy});
        check("step",   {31'b0, step},   {31'b0, m_step});
        check("wrap",   {31'b0, wrap},   {31'b0, m_wrap});
    endtask

    task automatic cyc1();
        model_cycle();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic pulse_start(input int lo, input int hi, input logic d, input logic md);
        lo_lim = 4'(lo); hi_lim = 4'(hi); dir_init = d; mode = md;
        start = 1'b1;
        cyc1();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc1();
        stop = 1'b0;
    endtask

    initial begin
        int step_cnt, wrap_cnt, c0, c1;
        int seq_q[$];
        int wrp_q[$];
        int exp_seq[7] = '{0, -1, -2, -1, 0, 1, 0};
        int exp_wrp[7] = '{0, 0, 0, 1, 0, 0, 1};

        rst_n = 1'b0;
        start = 0; stop = 0; pause = 0; mode = 0; dir_init = 0; load = 0;
        lo_lim = 0; hi_lim = 0; load_val = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        cyc1();

        // Wrap up through the full range
        pulse_start(-8, 7, 1'b0, 1'b0);
        step_cnt = 0; wrap_cnt = 0;
        for (int i = 0; i < 16 * TD; i++) begin
            cyc1();
            step_cnt += int'(step);
            wrap_cnt += int'(wrap);
        end
        check("wrapup_steps", step_cnt, 16);
        check("wrapup_wraps", wrap_cnt, 1);
        check("wrapup_last", {28'b0, number}, 32'h8);

        // Asynchronous reset mid-run, away from any clock edge
        repeat (5) cyc1();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;

        // Bounce down
        pulse_start(-2, 1, 1'b1, 1'b1);
        check("bounce_first", {28'b0, number}, 32'h1);
        for (int i = 0; i < 7 * TD; i++) begin
            cyc1();
            if (step) begin
                seq_q.push_back(sv4(number));
                wrp_q.push_back(int'(wrap));
            end
        end
        check("bounce_count", seq_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < seq_q.size()) begin
                check("bounce_val", seq_q[i], exp_seq[i]);
                check("bounce_wrap", wrp_q[i], exp_wrp[i]);
            end
        end

        // Pause for 6 cycles right after a step
        c0 = -1;
        for (int i = 0; i < 2 * TD && c0 < 0; i++) begin
            cyc1();
            if (step) c0 = cyc;
        end
        repeat (2) cyc1();
        pause = 1'b1;
        repeat (6) cyc1();
        pause = 1'b0;
        c1 = -1;
        for (int i = 0; i < 4 * TD && c1 < 0; i++) begin
            cyc1();
            if (step) c1 = cyc;
        end
        check("pause_spacing", c1 - c0, TD + 6);

        // stop and start together while running
        stop = 1'b1; start = 1'b1;
        cyc1();
        stop = 1'b0; start = 1'b0;
        check("stopstart_busy", {31'b0, busy}, 32'd0);
        check("stopstart_blank", {31'b0, blank}, 32'd1);

        // Load clamping against [-3, 3]
        pulse_start(-3, 3, 1'b0, 1'b0);
        repeat (6) cyc1();
        for (int k = 0; k < 2; k++) begin
            load_val = (k == 0) ? 4'd7 : 4'h8;
            load = 1'b1;
            cyc1();
            load = 1'b0;
            c0 = cyc;
            check("load_val", sv4(number), (k == 0) ? 3 : -3);
            check("load_nostep", {31'b0, step}, 32'd0);
            c1 = -1;
            for (int i = 0; i < 3 * TD && c1 < 0; i++) begin
                cyc1();
                if (step) c1 = cyc;
            end
            check("load_spacing", c1 - c0, TD);
        end
        pulse_stop();

        // Invalid limits are ignored
        pulse_start(2, -1, 1'b0, 1'b0);
        check("invalid_busy", {31'b0, busy}, 32'd0);
        check("invalid_blank", {31'b0, blank}, 32'd1);
        repeat (3) cyc1();

        // Degenerate range in bounce mode holds the value
        pulse_start(5, 5, 1'b0, 1'b1);
        step_cnt = 0; wrap_cnt = 0;
        for (int i = 0; i < 3 * TD; i++) begin
            cyc1();
            step_cnt += int'(step);
            wrap_cnt += int'(wrap);
            check("hold_val", sv4(number), 5);
        end
        check("hold_steps", step_cnt, 3);
        check("hold_wraps", wrap_cnt, 3);
        pulse_stop();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            stop     = ($urandom_range(99) < 2);
            start    = ($urandom_range(99) < 6);
            load     = ($urandom_range(99) < 4);
            pause    = ($urandom_range(99) < 12);
            mode     = 1'($urandom_range(1));
            dir_init = 1'($urandom_range(1));
            lo_lim   = 4'($urandom_range(15));
            hi_lim   = 4'($urandom_range(15));
            load_val = 4'($urandom_range(15));
            cyc1();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
